// File: rtl/xbar_cfg_pkg.sv
// Shared constants and FSM state type for the crossbar configuration loader.
// Latency: none (declarations only).
// Backpressure: not applicable.
package xbar_cfg_pkg;

    localparam int N_INPUTS   = 17;
    localparam int N_OUTPUTS  = 20;
    localparam int SEL_WIDTH  = 5;
    localparam int BEAT_WIDTH = 8;
    localparam int TOTAL      = N_OUTPUTS * SEL_WIDTH;
    localparam int BEATS      = (TOTAL + BEAT_WIDTH - 1) / BEAT_WIDTH;
    localparam int CNT_WIDTH  = $clog2(BEATS + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        CHECK  = 2'd2,
        COMMIT = 2'd3
    } state_t;

endpackage

// File: rtl/xbar_cfg_range_check.sv
// Flags a configuration image containing any select field that names a nonexistent input.
// Latency: purely combinational.
// Backpressure: not applicable.
module xbar_cfg_range_check
    import xbar_cfg_pkg::*;
(
    input  logic [TOTAL-1:0] cfg,
    output logic             illegal
);

    // Fields are SEL_WIDTH wide; the limit is truncated to that width so the compare is width-matched.
    // If N_INPUTS covers every encodable value, nothing can be illegal.
    localparam logic [SEL_WIDTH-1:0] LIMIT    = SEL_WIDTH'(N_INPUTS);
    localparam bit                   CHECK_ON = (N_INPUTS < (1 << SEL_WIDTH));

    // OR-reduce the per-field out-of-range compare.
    always_comb begin
        illegal = 1'b0;
        for (int i = 0; i < N_OUTPUTS; i++) begin
            if (CHECK_ON && (cfg[i*SEL_WIDTH +: SEL_WIDTH] >= LIMIT)) begin
                illegal = 1'b1;
            end
        end
    end

endmodule

// File: rtl/xbar_cfg_loader.sv
// Streams configuration beats into a shadow image, range-checks it, then commits it atomically to the crossbar.
// Latency: last beat accepted at E0 -> new io_mux_configs and io_cfg_done visible after E0+2.
// Backpressure: io_cfg_ready is high only in LOAD (registered from state); beats stall indefinitely on valid gaps.
module xbar_cfg_loader
    import xbar_cfg_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  io_cfg_start,
    input  logic                  io_cfg_valid,
    output logic                  io_cfg_ready,
    input  logic [BEAT_WIDTH-1:0] io_cfg_data,
    output logic                  io_cfg_busy,
    output logic                  io_cfg_done,
    output logic                  io_cfg_error,
    output logic [TOTAL-1:0]      io_mux_configs
);

    localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(BEATS - 1);

    state_t                 state;
    logic [CNT_WIDTH-1:0]   beat_cnt;
    logic [TOTAL-1:0]       shadow;
    logic [TOTAL-1:0]       shadow_nxt;
    logic                   pend_err;
    logic                   illegal;
    logic                   accept;

    // ready is only ever high in LOAD, so this is a LOAD-state handshake.
    assign accept = io_cfg_valid & io_cfg_ready;

    // Shadow image with the current beat dropped into its slot; bits past TOTAL in the last beat fall away.
    always_comb begin
        shadow_nxt = shadow;
        for (int j = 0; j < TOTAL; j++) begin
            if (beat_cnt == CNT_WIDTH'(j / BEAT_WIDTH)) begin
                shadow_nxt[j] = io_cfg_data[j % BEAT_WIDTH];
            end
        end
    end

    xbar_cfg_range_check u_range_check (
        .cfg     (shadow),
        .illegal (illegal)
    );

    // Loader FSM with registered ready/busy/done/error and the shadow/active configuration registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            beat_cnt       <= '0;
            shadow         <= '0;
            pend_err       <= 1'b0;
            io_cfg_ready   <= 1'b0;
            io_cfg_busy    <= 1'b0;
            io_cfg_done    <= 1'b0;
            io_cfg_error   <= 1'b0;
            io_mux_configs <= '0;
        end else begin
            io_cfg_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (io_cfg_start) begin
                        state        <= LOAD;
                        beat_cnt     <= '0;
                        io_cfg_error <= 1'b0;
                        io_cfg_ready <= 1'b1;
                        io_cfg_busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    // A restart wins over a coincident beat; stale shadow bits get overwritten by the new load.
                    if (io_cfg_start) begin
                        beat_cnt <= '0;
                    end else if (accept) begin
                        shadow   <= shadow_nxt;
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == LAST_BEAT) begin
                            state        <= CHECK;
                            io_cfg_ready <= 1'b0;
                        end
                    end
                end
                CHECK: begin
                    pend_err <= illegal;
                    state    <= COMMIT;
                end
                COMMIT: begin
                    if (pend_err) begin
                        io_cfg_error <= 1'b1;
                    end else begin
                        io_mux_configs <= shadow;
                    end
                    state       <= IDLE;
                    io_cfg_busy <= 1'b0;
                    io_cfg_done <= 1'b1;
                end
                default: begin
                    state        <= IDLE;
                    io_cfg_ready <= 1'b0;
                    io_cfg_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
